// File: rtl/drlp_sld_feeder.sv
// Streams column words from the column buffer into the sliding register file.
// Reads are paced by a 2-entry FIFO budget; shifts are paced by i_ready.
module drlp_sld_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 6,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic [ADDR_WIDTH-1:0]            i_base_addr,
    input  logic [7:0]                       i_num_cols,
    input  logic [1:0]                       i_mode,
    input  logic                             i_3x3,
    output logic                             o_rd_en,
    output logic [ADDR_WIDTH-1:0]            o_rd_addr,
    input  logic [DATA_WIDTH*ROW_NUM-1:0]    i_rd_data,
    input  logic                             i_ready,
    output logic [DATA_WIDTH*ROW_NUM-1:0]    o_data,
    output logic                             o_shift,
    output logic [1:0]                       o_mode,
    output logic                             o_3x3,
    output logic                             o_win_valid,
    output logic                             o_busy,
    output logic                             o_done
);
    localparam int DW = DATA_WIDTH * ROW_NUM;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [7:0]            r_count;
    logic [7:0]            r_issued;
    logic [7:0]            r_shift_cnt;
    logic [1:0]            r_mode;
    logic                  r_3x3;
    logic                  r_inflight;
    logic [DW-1:0]         r_fifo [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_occ;
    logic                  r_win_valid;

    logic                  w_start_ok;
    logic                  w_rd_en;
    logic                  w_shift;
    logic                  w_last_pop;
    logic [7:0]            w_shift_inc;
    logic [7:0]            w_fill;

    assign w_start_ok  = (r_state == S_IDLE) && i_start && (i_num_cols != 8'd0);
    // Budget counts the read already in flight so the FIFO can never overflow.
    assign w_rd_en     = (r_state == S_STREAM) && (r_issued < r_count) &&
                         (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd2);
    assign w_shift     = (r_occ != 2'd0) && i_ready;
    assign w_last_pop  = w_shift && (r_occ == 2'd1) && !r_inflight;
    assign w_shift_inc = (r_shift_cnt == 8'hFF) ? 8'hFF : r_shift_cnt + 8'd1;
    assign w_fill      = (r_mode == 2'b00) ? 8'd3 : 8'd6;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = (i_num_cols != 8'd0) ? S_STREAM : S_DONE;
            S_STREAM: if (r_issued == r_count) w_next = S_DRAIN;
            S_DRAIN:  if (w_last_pop) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_count     <= '0;
            r_issued    <= '0;
            r_shift_cnt <= '0;
            r_mode      <= '0;
            r_3x3       <= 1'b0;
            r_inflight  <= 1'b0;
            r_win_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_inflight  <= w_rd_en;
            r_win_valid <= w_shift && (w_shift_inc >= w_fill);
            if (w_start_ok) begin
                r_base      <= i_base_addr;
                r_count     <= i_num_cols;
                r_mode      <= i_mode;
                r_3x3       <= i_3x3;
                r_issued    <= '0;
                r_shift_cnt <= '0;
            end else begin
                if (w_rd_en) r_issued <= r_issued + 8'd1;
                if (w_shift) r_shift_cnt <= w_shift_inc;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_fifo[r_wptr] <= i_rd_data;
                r_wptr         <= ~r_wptr;
            end
            if (w_shift) r_rptr <= ~r_rptr;
            case ({r_inflight, w_shift})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_rd_en     = w_rd_en;
    assign o_rd_addr   = r_base + ADDR_WIDTH'(r_issued);
    assign o_data      = r_fifo[r_rptr];
    assign o_shift     = w_shift;
    assign o_mode      = r_mode;
    assign o_3x3       = r_3x3;
    assign o_win_valid = r_win_valid;
    assign o_busy      = (r_state == S_STREAM) || (r_state == S_DRAIN);
    assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_drlp_sld_feeder.sv
// Directed bench for drlp_sld_feeder: queued expected addresses/data, checked on read and shift.
module tb_drlp_sld_feeder;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [9:0]  i_base_addr;
    logic [7:0]  i_num_cols;
    logic [1:0]  i_mode;
    logic        i_3x3;
    logic        o_rd_en;
    logic [9:0]  o_rd_addr;
    logic [47:0] i_rd_data;
    logic        i_ready;
    logic [47:0] o_data;
    logic        o_shift;
    logic [1:0]  o_mode;
    logic        o_3x3;
    logic        o_win_valid;
    logic        o_busy;
    logic        o_done;

    drlp_sld_feeder #(.DATA_WIDTH(8), .ROW_NUM(6), .ADDR_WIDTH(10)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_num_cols(i_num_cols), .i_mode(i_mode), .i_3x3(i_3x3), .o_rd_en(o_rd_en),
        .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .i_ready(i_ready), .o_data(o_data),
        .o_shift(o_shift), .o_mode(o_mode), .o_3x3(o_3x3), .o_win_valid(o_win_valid),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] pat(input logic [9:0] a);
        return {8'hC5, 20'h0, a, ~a};
    endfunction

    // Column buffer model: data valid the cycle after the read strobe.
    always @(posedge i_clk) i_rd_data <= o_rd_en ? pat(o_rd_addr) : 48'hBAD0_BAD0_BAD0;

    logic [9:0]  exp_addr_q [$];
    logic [47:0] exp_data_q [$];

    int         cyc = 0;
    int         pass_n = 0, pass_shifts = 0, pass_issued = 0, wv_cnt = 0;
    int         start_cyc = 0, last_shift_cyc = 0, done_cnt = 0;
    int         fill = 6;
    logic       exp_wv = 1'b0;
    logic [1:0] exp_mode = 2'b00;
    logic       exp_3x3 = 1'b0;

    always @(negedge i_clk) begin
        cyc++;
        if (!i_rst) begin
            exp_wv = 1'b0;
        end else begin
            chk("win_valid", o_win_valid, exp_wv);
            if (o_win_valid) wv_cnt++;
            exp_wv = 1'b0;
            if (o_rd_en) begin
                chk("outstanding_le_2", (pass_issued - pass_shifts) < 2, 1);
                if (exp_addr_q.size() == 0) chk("extra_read", 1, 0);
                else chk("rd_addr", o_rd_addr, exp_addr_q.pop_front());
                pass_issued++;
            end
            if (o_shift) begin
                if (exp_data_q.size() == 0) chk("extra_shift", 1, 0);
                else chk("shift_data", o_data, exp_data_q.pop_front());
                pass_shifts++;
                last_shift_cyc = cyc;
                exp_wv = (pass_shifts >= fill);
            end
            if (o_done) begin
                done_cnt++;
                chk("done_time", cyc, (pass_n == 0) ? start_cyc + 1 : last_shift_cyc + 1);
                chk("shift_total", pass_shifts, pass_n);
                chk("win_valid_total", wv_cnt, (pass_n >= fill) ? pass_n - fill + 1 : 0);
                chk("busy_at_done", o_busy, 0);
                if (pass_n > 0) begin
                    chk("mode_latched", o_mode, exp_mode);
                    chk("x3_latched", o_3x3, exp_3x3);
                end
            end
            if (i_start && !o_busy && !o_done) begin
                start_cyc   = cyc;
                pass_n      = int'(i_num_cols);
                pass_shifts = 0;
                pass_issued = 0;
                wv_cnt      = 0;
                if (i_num_cols != 8'd0) begin
                    fill     = (i_mode == 2'b00) ? 3 : 6;
                    exp_mode = i_mode;
                    exp_3x3  = i_3x3;
                end
            end
        end
    end

    task automatic do_start(input logic [9:0] base, input int n, input logic [1:0] mode, input logic x3);
        logic [9:0] a;
        for (int k = 0; k < n; k++) begin
            a = base + 10'(k);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(pat(a));
        end
        @(posedge i_clk); #1;
        i_start = 1'b1; i_base_addr = base; i_num_cols = 8'(n); i_mode = mode; i_3x3 = x3;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int rmode);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < 400) begin
            i_ready = (rmode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            @(posedge i_clk); #1;
            k++;
        end
        i_ready = 1'b1;
        chk("pass_completes", done_cnt != d0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, o_rd_en, 0);
        chk({tag, "_shift"}, o_shift, 0);
        chk({tag, "_win_valid"}, o_win_valid, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_mode"}, o_mode, 0);
        chk({tag, "_3x3"}, o_3x3, 0);
        chk({tag, "_rd_addr"}, o_rd_addr, 0);
        chk({tag, "_data"}, o_data, 0);
    endtask

    initial begin
        int k;
        i_rst = 1'b0; i_start = 1'b0; i_base_addr = '0; i_num_cols = '0;
        i_mode = '0; i_3x3 = 1'b0; i_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk_all_zero("reset");
        i_rst = 1'b1;

        // Basic 8-column pass, window valid from the 6th shift.
        do_start(10'h010, 8, 2'b01, 1'b0);
        wait_done(0);

        // 3x3 mode: fill depth 3, latched mode/select visible.
        do_start(10'h020, 4, 2'b00, 1'b1);
        wait_done(0);
        chk("mode_after_3x3_pass", o_mode, 2'b00);
        chk("x3_after_3x3_pass", o_3x3, 1);

        // Backpressure pattern 1,0,0,1.
        do_start(10'h050, 10, 2'b10, 1'b0);
        wait_done(1);

        // Address wrap.
        do_start(10'h3FE, 4, 2'b01, 1'b0);
        wait_done(0);

        // Zero columns completes immediately with no traffic.
        do_start(10'h123, 0, 2'b01, 1'b0);
        wait_done(0);

        // Start while busy is ignored.
        do_start(10'h040, 6, 2'b01, 1'b0);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_start = 1'b1; i_base_addr = 10'h200; i_num_cols = 8'd3; i_mode = 2'b00;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done(0);
        chk("mode_kept_after_ignored_start", o_mode, 2'b01);

        // Reset after 3 of 8 shifts, released before the pending read data lands.
        do_start(10'h080, 8, 2'b01, 1'b0);
        k = 0;
        while (pass_shifts < 3 && k < 100) begin
            @(posedge i_clk); #1;
            k++;
        end
        chk("three_shifts_reached", pass_shifts, 3);
        i_rst = 1'b0;
        #1;
        chk_all_zero("midpass_reset");
        exp_addr_q.delete();
        exp_data_q.delete();
        #1;
        i_rst = 1'b1;
        do_start(10'h100, 5, 2'b11, 1'b1);
        wait_done(0);
        chk("queues_drained", exp_addr_q.size() + exp_data_q.size(), 0);

        repeat (3) @(posedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
